bsg_manycore_spmd_receiver: RTL

//  Tile-side endpoint for SPMD program-load traffic. Accepts manycore packets addressed to this tile,

---
 rtl/bsg_manycore_spmd_receiver.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bsg_manycore_spmd_receiver.sv
// Tile-side SPMD program-load endpoint: buffers manycore packets in a 2-entry FIFO,
// turns local stores into memory writes, and releases the core freeze on an unfreeze packet.
module bsg_manycore_spmd_receiver #(
   parameter int mem_size_p   = 1024,
   parameter int data_width_p = 32,
   parameter int addr_width_p = 30,
   parameter int num_rows_p   = 4,
   parameter int num_cols_p   = 4,
   parameter int cnt_width_p  = 16,
   localparam int y_cord_width_lp   = ((num_rows_p + 1) <= 1) ? 1 : $clog2(num_rows_p + 1),
   localparam int x_cord_width_lp   = (num_cols_p <= 1) ? 1 : $clog2(num_cols_p),
   localparam int mask_width_lp     = data_width_p / 8,
   localparam int packet_width_lp   = addr_width_p + 2 + mask_width_lp + data_width_p
                                      + 2 * (x_cord_width_lp + y_cord_width_lp),
   localparam int mem_addr_width_lp = $clog2(mem_size_p / 4)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [packet_width_lp-1:0]   data_i,
   input  logic                         v_i,
   output logic                         ready_o,
   input  logic [x_cord_width_lp-1:0]   my_x_i,
   input  logic [y_cord_width_lp-1:0]   my_y_i,
   output logic                         mem_v_o,
   output logic [mem_addr_width_lp-1:0] mem_addr_o,
   output logic [data_width_p-1:0]      mem_data_o,
   output logic [mask_width_lp-1:0]     mem_mask_o,
   input  logic                         mem_yumi_i,
   output logic                         freeze_o,
   output logic                         arb_cfg_o,
   output logic [cnt_width_p-1:0]       words_loaded_o,
   output logic                         err_o
);

   typedef struct packed {
      logic [addr_width_p-1:0]    addr;
      logic [1:0]                 op;
      logic [mask_width_lp-1:0]   op_ex;
      logic [data_width_p-1:0]    payload;
      logic [y_cord_width_lp-1:0] src_y_cord;
      logic [x_cord_width_lp-1:0] src_x_cord;
      logic [y_cord_width_lp-1:0] y_cord;
      logic [x_cord_width_lp-1:0] x_cord;
   } packet_s;

   typedef enum logic {FROZEN, RUN} state_e;

   localparam logic [addr_width_p-1:0] mem_words_lp = addr_width_p'(mem_size_p / 4);
   localparam logic [1:0] op_store_lp    = 2'b01;
   localparam logic [1:0] op_unfreeze_lp = 2'b10;

   packet_s    fifo_mem [2];
   logic       wr_ptr, rd_ptr;
   logic [1:0] count;
   logic       full, empty, enq, deq;

   state_e     state;
   packet_s    head;
   logic       hit, is_unfreeze, is_cfg, is_store, is_drop;
   logic       unused_bits;

   // ---- input FIFO: registered, no bypass ----
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign ready_o = ~reset_i & ~full;
   assign enq     = v_i & ready_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (enq) wr_ptr <= ~wr_ptr;
         if (deq) rd_ptr <= ~rd_ptr;
         case ({enq, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) fifo_mem[wr_ptr] <= packet_s'(data_i);
   end

   // ---- head decode: destination, unfreeze, cfg word, store, else drop ----
   assign head = fifo_mem[rd_ptr];

   always_comb begin
      hit         = (head.x_cord == my_x_i) && (head.y_cord == my_y_i);
      is_unfreeze = hit && (head.op == op_unfreeze_lp);
      is_cfg      = hit && (head.op == op_store_lp) && (state == RUN)
                    && (head.addr == addr_width_p'(1));
      is_store    = hit && (head.op == op_store_lp) && !is_cfg && (head.addr < mem_words_lp);
      is_drop     = !(is_unfreeze || is_cfg || is_store);
   end

   assign mem_v_o    = ~empty & is_store;
   assign mem_addr_o = head.addr[mem_addr_width_lp-1:0];
   assign mem_data_o = head.payload;
   assign mem_mask_o = head.op_ex;
   // Stores wait for the memory handshake; every other head type retires in one cycle.
   assign deq        = ~empty & (~is_store | mem_yumi_i);

   assign unused_bits = ^{head.src_x_cord, head.src_y_cord};

   // ---- freeze FSM and status registers ----
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state          <= FROZEN;
         arb_cfg_o      <= 1'b0;
         err_o          <= 1'b0;
         words_loaded_o <= '0;
      end else begin
         if (deq && is_unfreeze) state <= RUN;
         if (deq && is_cfg)      arb_cfg_o <= head.payload[0];
         if (deq && is_drop)     err_o <= 1'b1;
         if (mem_v_o && mem_yumi_i && (state == FROZEN) && !(&words_loaded_o))
            words_loaded_o <= words_loaded_o + cnt_width_p'(1);
      end
   end

   assign freeze_o = (state == FROZEN);

endmodule
